// File: rtl/traffic_intersection_ctrl_if.sv
// rtl/traffic_intersection_ctrl_if.sv - demand inputs, lamp outputs and state code of the intersection controller
interface traffic_intersection_ctrl_if;
  logic       side_car;
  logic       ped_req;
  logic       main_red;
  logic       main_yellow;
  logic       main_green;
  logic       side_red;
  logic       side_yellow;
  logic       side_green;
  logic       walk;
  logic [2:0] state;

  modport master (
    output side_car, ped_req,
    input  main_red, main_yellow, main_green,
    input  side_red, side_yellow, side_green,
    input  walk, state
  );

  modport slave (
    input  side_car, ped_req,
    output main_red, main_yellow, main_green,
    output side_red, side_yellow, side_green,
    output walk, state
  );
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - two-road plus pedestrian Moore controller with a shared phase timer
module traffic_intersection_ctrl #(
  parameter int CNT_W        = 8,
  parameter int T_GREEN_MAIN = 20,
  parameter int T_GREEN_SIDE = 10,
  parameter int T_YELLOW     = 3,
  parameter int T_ALLRED     = 1,
  parameter int T_WALK       = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  traffic_intersection_ctrl_if.slave    ctrl_if
);

  typedef enum logic [2:0] {
    ST_MAIN_GREEN  = 3'd0,
    ST_MAIN_YELLOW = 3'd1,
    ST_ALL_RED_A   = 3'd2,
    ST_SIDE_GREEN  = 3'd3,
    ST_SIDE_YELLOW = 3'd4,
    ST_ALL_RED_B   = 3'd5,
    ST_WALK        = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] LD_GREEN_MAIN = CNT_W'(T_GREEN_MAIN - 1);
  localparam logic [CNT_W-1:0] LD_GREEN_SIDE = CNT_W'(T_GREEN_SIDE - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW     = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED     = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_WALK       = CNT_W'(T_WALK - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             side_pend_q, side_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic             expired;
  logic [CNT_W-1:0] load_val;

  assign expired = (timer_q == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_MAIN_GREEN;
      timer_q     <= LD_GREEN_MAIN;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
    end
  end

  // Decisions use the registered latches, so same-cycle demand waits for the next decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MAIN_GREEN:  if (expired && (side_pend_q || ped_pend_q)) state_d = ST_MAIN_YELLOW;
      ST_MAIN_YELLOW: if (expired) state_d = ST_ALL_RED_A;
      ST_ALL_RED_A:   if (expired) state_d = side_pend_q ? ST_SIDE_GREEN : ST_WALK;
      ST_SIDE_GREEN:  if (expired) state_d = ST_SIDE_YELLOW;
      ST_SIDE_YELLOW: if (expired) state_d = ST_ALL_RED_B;
      ST_ALL_RED_B:   if (expired) state_d = ped_pend_q ? ST_WALK : ST_MAIN_GREEN;
      ST_WALK:        if (expired) state_d = ST_MAIN_GREEN;
      default:        state_d = ST_MAIN_GREEN;
    endcase
  end

  always_comb begin
    load_val = LD_GREEN_MAIN;
    case (state_d)
      ST_MAIN_YELLOW, ST_SIDE_YELLOW: load_val = LD_YELLOW;
      ST_ALL_RED_A, ST_ALL_RED_B:     load_val = LD_ALLRED;
      ST_SIDE_GREEN:                  load_val = LD_GREEN_SIDE;
      ST_WALK:                        load_val = LD_WALK;
      default:                        load_val = LD_GREEN_MAIN;
    endcase
  end

  // Any state change (including recovery from the unused code) reloads the timer.
  always_comb begin
    timer_d = expired ? '0 : timer_q - 1'b1;
    if (state_d != state_q) timer_d = load_val;
  end

  always_comb begin
    side_pend_d = side_pend_q;
    ped_pend_d  = ped_pend_q;
    if (state_d == ST_SIDE_GREEN && state_q != ST_SIDE_GREEN) side_pend_d = 1'b0;
    if (state_d == ST_WALK && state_q != ST_WALK)             ped_pend_d  = 1'b0;
    if (ctrl_if.side_car) side_pend_d = 1'b1;
    if (ctrl_if.ped_req)  ped_pend_d  = 1'b1;
  end

  assign ctrl_if.main_green  = (state_q == ST_MAIN_GREEN);
  assign ctrl_if.main_yellow = (state_q == ST_MAIN_YELLOW);
  assign ctrl_if.main_red    = !(state_q == ST_MAIN_GREEN || state_q == ST_MAIN_YELLOW);
  assign ctrl_if.side_green  = (state_q == ST_SIDE_GREEN);
  assign ctrl_if.side_yellow = (state_q == ST_SIDE_YELLOW);
  assign ctrl_if.side_red    = !(state_q == ST_SIDE_GREEN || state_q == ST_SIDE_YELLOW);
  assign ctrl_if.walk        = (state_q == ST_WALK);
  assign ctrl_if.state       = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb/tb_traffic_intersection_ctrl.sv - table-driven bench for the intersection controller
module tb_traffic_intersection_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cur_cyc = 0;

  traffic_intersection_ctrl_if bus ();

  traffic_intersection_ctrl dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .ctrl_if (bus.slave)
  );

  always #5 clk = ~clk;

  // Scenario 0: no demand. 1: side_car held. 2: ped pulse at 5.
  // 3: side and ped pulse at 2. 4: ped pulses at 5 and 23 (edge entering WALK).
  typedef struct {
    int         scen;
    int         lo;
    int         hi;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int s, input int lo, input int hi, input logic [2:0] st);
    vec_t v;
    v.scen = s; v.lo = lo; v.hi = hi; v.st = st;
    vecs.push_back(v);
  endtask

  // {main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk}
  function automatic logic [6:0] lamps_for(input logic [2:0] s);
    case (s)
      3'd0:    return 7'b001_100_0;
      3'd1:    return 7'b010_100_0;
      3'd3:    return 7'b100_001_0;
      3'd4:    return 7'b100_010_0;
      3'd6:    return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  function automatic logic [6:0] lamps_now();
    return {bus.main_red, bus.main_yellow, bus.main_green,
            bus.side_red, bus.side_yellow, bus.side_green, bus.walk};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cur_cyc, act, exp);
    end
  endtask

  task automatic check_inv();
    logic [6:0] l;
    logic ok;
    l  = lamps_now();
    ok = $onehot(l[6:4]) && $onehot(l[3:1])
         && !(l[0] && (l[5] || l[4] || l[2] || l[1]))
         && (l[6] || l[3]);
    check("invariant", {31'd0, ok}, 32'd1);
  endtask

  task automatic stim(input int s, input int c);
    bus.side_car = (s == 1) || (s == 3 && c == 2);
    bus.ped_req  = (s == 2 && c == 5) || (s == 3 && c == 2) || (s == 4 && (c == 5 || c == 23));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.side_car = 1'b0;
    bus.ped_req  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", {29'd0, bus.state}, 32'd0);
    check("rst_lamps", {25'd0, lamps_now()}, {25'd0, 7'b001_100_0});
    rst_n = 1'b1;
  endtask

  // Called at the falling edge before rising edge 0; cycle c is the state seen by edge c.
  task automatic run_cycles(input int s, input int n);
    for (int c = 0; c < n; c++) begin
      cur_cyc = c;
      stim(s, c);
      #1;
      check_inv();
      foreach (vecs[i]) begin
        if (vecs[i].scen == s && c >= vecs[i].lo && c <= vecs[i].hi) begin
          check("state", {29'd0, bus.state}, {29'd0, vecs[i].st});
          check("lamps", {25'd0, lamps_now()}, {25'd0, lamps_for(vecs[i].st)});
        end
      end
      if (s == 2 && c == 40) check("ped_pend_cleared", {31'd0, dut.ped_pend_q}, 32'd0);
      if (s == 3 && c == 24) check("ped_pend_waiting", {31'd0, dut.ped_pend_q}, 32'd1);
      if (s == 3 && c == 24) check("side_pend_cleared", {31'd0, dut.side_pend_q}, 32'd0);
      if (s == 4 && c == 30) check("ped_pend_kept", {31'd0, dut.ped_pend_q}, 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    bus.side_car = 1'b0;
    bus.ped_req  = 1'b0;

    add(0, 0, 199, 3'd0);

    add(1, 0, 19, 3'd0);  add(1, 20, 22, 3'd1); add(1, 23, 23, 3'd2);
    add(1, 24, 33, 3'd3); add(1, 34, 36, 3'd4); add(1, 37, 37, 3'd5);
    add(1, 38, 57, 3'd0); add(1, 58, 60, 3'd1); add(1, 61, 61, 3'd2);
    add(1, 62, 71, 3'd3);

    add(2, 0, 19, 3'd0);  add(2, 20, 22, 3'd1); add(2, 23, 23, 3'd2);
    add(2, 24, 29, 3'd6); add(2, 30, 54, 3'd0);

    add(3, 0, 19, 3'd0);  add(3, 20, 22, 3'd1); add(3, 23, 23, 3'd2);
    add(3, 24, 33, 3'd3); add(3, 34, 36, 3'd4); add(3, 37, 37, 3'd5);
    add(3, 38, 43, 3'd6); add(3, 44, 59, 3'd0);

    add(4, 0, 19, 3'd0);  add(4, 20, 22, 3'd1); add(4, 23, 23, 3'd2);
    add(4, 24, 29, 3'd6); add(4, 30, 49, 3'd0); add(4, 50, 52, 3'd1);
    add(4, 53, 53, 3'd2); add(4, 54, 59, 3'd6); add(4, 60, 64, 3'd0);

    @(negedge clk);
    apply_reset(); run_cycles(0, 200);
    apply_reset(); run_cycles(1, 72);
    apply_reset(); run_cycles(2, 55);
    apply_reset(); run_cycles(3, 60);
    apply_reset(); run_cycles(4, 65);

    // Asynchronous reset in the middle of side green, then a full main-green minimum.
    apply_reset();
    run_cycles(1, 28);
    cur_cyc = 28;
    check("pre_reset_state", {29'd0, bus.state}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", {29'd0, bus.state}, 32'd0);
    check("async_lamps", {25'd0, lamps_now()}, {25'd0, 7'b001_100_0});
    check("async_side_pend", {31'd0, dut.side_pend_q}, 32'd0);
    apply_reset();
    run_cycles(1, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
